// File: rtl/uart_pkg.sv
// Shared encodings for the configurable UART receiver: FSM states, parity modes,
// character-length codes and small decode helpers.
package uart_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

  localparam logic [1:0] PAR_NONE     = 2'd0;
  localparam logic [1:0] PAR_EVEN     = 2'd1;
  localparam logic [1:0] PAR_ODD      = 2'd2;
  localparam logic [1:0] PAR_NONE_ALT = 2'd3;

  localparam logic [1:0] DBITS_5 = 2'd0;
  localparam logic [1:0] DBITS_6 = 2'd1;
  localparam logic [1:0] DBITS_7 = 2'd2;
  localparam logic [1:0] DBITS_8 = 2'd3;

  function automatic logic [3:0] char_len(input logic [1:0] code);
    logic [3:0] len;
    len = 4'd8;
    case (code)
      DBITS_5: len = 4'd5;
      DBITS_6: len = 4'd6;
      DBITS_7: len = 4'd7;
      DBITS_8: len = 4'd8;
    endcase
    return len;
  endfunction

  function automatic logic parity_enabled(input logic [1:0] mode);
    logic en;
    en = 1'b0;
    case (mode)
      PAR_EVEN, PAR_ODD:      en = 1'b1;
      PAR_NONE, PAR_NONE_ALT: en = 1'b0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchroniser for rx (flops reset to the idle-high level). With
// UART_RX_MAJORITY_EN defined it also provides a 2-of-3 majority of the last three rxs samples.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rxs
`ifdef UART_RX_MAJORITY_EN
  ,
  output logic rxs_maj
`endif
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], rx};

  // NOTE: flops use <= so every stage captures its neighbour's pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= sync_d;
  end

  assign rxs = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q, hist_d;

  always_comb hist_d = {hist_q[0], rxs};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist_q <= '1;
    else        hist_q <= hist_d;
  end

  assign rxs_maj = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs) | (hist_q[0] & rxs);
`endif

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver (5-8 data bits, none/even/odd parity, 1/2 stop bits).
// Define UART_RX_MAJORITY_EN to take each bit decision from a 3-sample majority vote.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLOCK_SCALE_BITS = 16,
  parameter int SYNC_STAGES      = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CLOCK_SCALE_BITS-1:0] cyclesPerBit,
  input  logic [1:0]                  dataBits,
  input  logic [1:0]                  parityMode,
  input  logic                        stopBits,
  input  logic                        rx,
  output logic [7:0]                  dataOut,
  output logic                        dataAvailable,
  output logic                        parityError,
  output logic                        frameError,
  output logic                        breakDetect
);

  localparam logic [CLOCK_SCALE_BITS-1:0] CNT_ONE = CLOCK_SCALE_BITS'(1);

  logic rxs, bit_val;

`ifdef UART_RX_MAJORITY_EN
  // The vote needs the sample after the nominal point, so decisions lag one cycle.
  localparam logic [CLOCK_SCALE_BITS-1:0] DECIDE_LAG = CLOCK_SCALE_BITS'(1);
  logic rxs_maj;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (rx),
    .rxs     (rxs),
    .rxs_maj (rxs_maj)
  );
  assign bit_val = rxs_maj;
`else
  localparam logic [CLOCK_SCALE_BITS-1:0] DECIDE_LAG = '0;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .rxs   (rxs)
  );
  assign bit_val = rxs;
`endif

  logic [2:0]                  state_q, state_d;
  logic [CLOCK_SCALE_BITS-1:0] cnt_q, cnt_d;
  logic [2:0]                  idx_q, idx_d;
  logic [1:0]                  len_q, len_d;
  logic [1:0]                  par_mode_q, par_mode_d;
  logic                        stop2_q, stop2_d;
  logic                        second_stop_q, second_stop_d;
  logic [7:0]                  shift_q, shift_d;
  logic                        perr_pend_q, perr_pend_d;
  logic                        par_bit_q, par_bit_d;
  logic [7:0]                  data_out_q, data_out_d;
  logic                        avail_q, avail_d;
  logic                        perr_q, perr_d;
  logic                        ferr_q, ferr_d;
  logic                        brk_q, brk_d;

  logic [CLOCK_SCALE_BITS-1:0] half, start_pt, cnt_next;
  logic                        terminal;
  logic [3:0]                  last_idx;

  assign half     = cyclesPerBit >> 1;
  assign start_pt = half - CNT_ONE + DECIDE_LAG;
  assign terminal = (cnt_q == cyclesPerBit - CNT_ONE);
  assign cnt_next = terminal ? '0 : cnt_q + CNT_ONE;
  assign last_idx = char_len(len_q) - 4'd1;

  always_comb begin
    // NOTE: every _d gets a default here so no path can infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    len_d         = len_q;
    par_mode_d    = par_mode_q;
    stop2_d       = stop2_q;
    second_stop_d = second_stop_q;
    shift_d       = shift_q;
    perr_pend_d   = perr_pend_q;
    par_bit_d     = par_bit_q;
    data_out_d    = data_out_q;
    avail_d       = 1'b0;
    perr_d        = perr_q;
    ferr_d        = ferr_q;
    brk_d         = brk_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rxs) begin
          state_d       = ST_START;
          len_d         = dataBits;
          par_mode_d    = parityMode;
          stop2_d       = stopBits;
          second_stop_d = 1'b0;
          shift_d       = '0;
          perr_pend_d   = 1'b0;
          par_bit_d     = 1'b0;
        end
      end
      ST_START: begin
        cnt_d = cnt_next;
        if (cnt_q == start_pt) begin
          cnt_d   = '0;
          state_d = bit_val ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        cnt_d = cnt_next;
        if (terminal) begin
          shift_d[idx_q] = bit_val;
          if ({1'b0, idx_q} == last_idx) begin
            idx_d   = '0;
            state_d = parity_enabled(par_mode_q) ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        cnt_d = cnt_next;
        if (terminal) begin
          par_bit_d   = bit_val;
          perr_pend_d = ((^shift_q) ^ bit_val) != (par_mode_q == PAR_ODD);
          state_d     = ST_STOP;
        end
      end
      ST_STOP: begin
        cnt_d = cnt_next;
        if (terminal) begin
          // Only the first stop bit completes the character; the second just gates IDLE.
          if (!second_stop_q) begin
            avail_d    = 1'b1;
            data_out_d = shift_q;
            perr_d     = perr_pend_q;
            ferr_d     = !bit_val;
            brk_d      = (shift_q == 8'h00) && !par_bit_q && !bit_val;
          end
          if (!bit_val) begin
            state_d = ST_WAIT_HIGH;
            cnt_d   = '0;
          end else if (stop2_q && !second_stop_q) begin
            second_stop_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
      end
      ST_WAIT_HIGH: begin
        cnt_d = '0;
        if (rxs) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      len_q         <= '0;
      par_mode_q    <= '0;
      stop2_q       <= 1'b0;
      second_stop_q <= 1'b0;
      shift_q       <= '0;
      perr_pend_q   <= 1'b0;
      par_bit_q     <= 1'b0;
      data_out_q    <= '0;
      avail_q       <= 1'b0;
      perr_q        <= 1'b0;
      ferr_q        <= 1'b0;
      brk_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      len_q         <= len_d;
      par_mode_q    <= par_mode_d;
      stop2_q       <= stop2_d;
      second_stop_q <= second_stop_d;
      shift_q       <= shift_d;
      perr_pend_q   <= perr_pend_d;
      par_bit_q     <= par_bit_d;
      data_out_q    <= data_out_d;
      avail_q       <= avail_d;
      perr_q        <= perr_d;
      ferr_q        <= ferr_d;
      brk_q         <= brk_d;
    end
  end

  assign dataOut       = data_out_q;
  assign dataAvailable = avail_q;
  assign parityError   = perr_q;
  assign frameError    = ferr_q;
  assign breakDetect   = brk_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: directed frames plus randomized configurations,
// compared against a character-level model of what each frame should report.
module tb_uart_rx_cfg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cyclesPerBit;
  logic [1:0]  dataBits;
  logic [1:0]  parityMode;
  logic        stopBits;
  logic        rx;
  logic [7:0]  dataOut;
  logic        dataAvailable;
  logic        parityError;
  logic        frameError;
  logic        breakDetect;

  int checks   = 0;
  int failures = 0;

  // Each entry: {data[7:0], parityError, frameError, breakDetect}
  logic [10:0] obs_q[$];
  logic [10:0] exp_q[$];

  uart_rx_cfg #(.CLOCK_SCALE_BITS(16), .SYNC_STAGES(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cyclesPerBit  (cyclesPerBit),
    .dataBits      (dataBits),
    .parityMode    (parityMode),
    .stopBits      (stopBits),
    .rx            (rx),
    .dataOut       (dataOut),
    .dataAvailable (dataAvailable),
    .parityError   (parityError),
    .frameError    (frameError),
    .breakDetect   (breakDetect)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_n && dataAvailable === 1'b1)
      obs_q.push_back({dataOut, parityError, frameError, breakDetect});

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b, input bit glitch);
    int cpb;
    int hp;
    cpb = int'(cyclesPerBit);
    hp  = cpb / 2;
    rx  = b;
    if (glitch) begin
      repeat (hp) @(negedge clk);
      rx = ~b;
      @(negedge clk);
      rx = b;
      repeat (cpb - hp - 1) @(negedge clk);
    end else begin
      repeat (cpb) @(negedge clk);
    end
  endtask

  // Sends one frame with the current configuration and queues what it should report.
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic s1,
                            input logic s2, input int glitch_bit);
    int         n;
    logic [1:0] db_save, pm_save;
    logic       sb_save, pen;
    logic [7:0] dm;
    logic       perr, ferr, brk;
    db_save = dataBits;
    pm_save = parityMode;
    sb_save = stopBits;
    n   = 5 + int'(dataBits);
    dm  = d & (8'hFF >> (8 - n));
    pen = (parityMode == 2'd1) || (parityMode == 2'd2);
    perr = pen && (((^dm) ^ pbit) != (parityMode == 2'd2));
    ferr = !s1;
    brk  = (dm == 8'h00) && (!pen || !pbit) && !s1;
    exp_q.push_back({dm, perr, ferr, brk});

    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      drive_bit(d[i], i == glitch_bit);
      if (i == 0) begin
        dataBits   = 2'($urandom);
        parityMode = 2'($urandom);
        stopBits   = 1'($urandom);
      end
    end
    dataBits   = db_save;
    parityMode = pm_save;
    stopBits   = sb_save;
    if (pen) drive_bit(pbit, 1'b0);
    drive_bit(s1, 1'b0);
    if (sb_save) drive_bit(s2, 1'b0);
  endtask

  task automatic settle_compare(input string tag);
    int n;
    idle(2 * int'(cyclesPerBit) + 8);
    check({tag, "_npulse"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_data"}, obs_q[i][10:3], exp_q[i][10:3]);
      check({tag, "_perr"}, obs_q[i][2], exp_q[i][2]);
      check({tag, "_ferr"}, obs_q[i][1], exp_q[i][1]);
      check({tag, "_brk"},  obs_q[i][0], exp_q[i][0]);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_dataOut"}, dataOut, 8'h00);
    check({tag, "_avail"},   dataAvailable, 1'b0);
    check({tag, "_perr"},    parityError, 1'b0);
    check({tag, "_ferr"},    frameError, 1'b0);
    check({tag, "_brk"},     breakDetect, 1'b0);
  endtask

  initial begin
    rst_n        = 1'b0;
    rx           = 1'b1;
    cyclesPerBit = 16'd16;
    dataBits     = 2'd3;
    parityMode   = 2'd0;
    stopBits     = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    idle(10);

    // 8N1 basic frame
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, -1);
    settle_compare("8n1_a5");

    // 7E1: 0x41 has even weight, so parity bit 1 is wrong and 0 is right
    dataBits   = 2'd2;
    parityMode = 2'd1;
    send_frame(8'h41, 1'b1, 1'b1, 1'b1, -1);
    settle_compare("7e1_bad");
    send_frame(8'h41, 1'b0, 1'b1, 1'b1, -1);
    settle_compare("7e1_ok");

    // 8N2 with a low second stop bit, then a clean frame
    dataBits   = 2'd3;
    parityMode = 2'd0;
    stopBits   = 1'b1;
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0, -1);
    settle_compare("8n2_stop2low");
    send_frame(8'hC3, 1'b0, 1'b1, 1'b1, -1);
    settle_compare("8n2_next");

    // Break: line low for 20 bit periods
    stopBits = 1'b0;
    exp_q.push_back({8'h00, 1'b0, 1'b1, 1'b1});
    rx = 1'b0;
    repeat (20 * 16) @(negedge clk);
    settle_compare("break");
    send_frame(8'h55, 1'b0, 1'b1, 1'b1, -1);
    settle_compare("after_break");

    // False start: 5-cycle low pulse
    rx = 1'b0;
    repeat (5) @(negedge clk);
    settle_compare("false_start");

`ifdef UART_RX_MAJORITY_EN
    send_frame(8'h00, 1'b0, 1'b1, 1'b1, 3);
    settle_compare("glitch");
    send_frame(8'h55, 1'b0, 1'b1, 1'b1, -1);
    settle_compare("pre_reset");
`endif

    // Reset during data bit 4 of 0xFF
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b1;
      repeat (16) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    settle_compare("midreset_nopulse");
    send_frame(8'h12, 1'b0, 1'b1, 1'b1, -1);
    settle_compare("after_reset");

    // Randomized configurations, 1-3 back-to-back frames per batch
    for (int it = 0; it < 30; it++) begin
      int nfr;
      cyclesPerBit = 16'($urandom_range(4, 24));
      dataBits     = 2'($urandom);
      parityMode   = 2'($urandom);
      stopBits     = 1'($urandom);
      nfr          = $urandom_range(1, 3);
      for (int f = 0; f < nfr; f++) begin
        logic [7:0] d;
        logic       pbit, s1, s2, last;
        int         n;
        d    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        n    = 5 + int'(dataBits);
        pbit = ^(d & (8'hFF >> (8 - n)));
        if (parityMode == 2'd2) pbit = ~pbit;
        if ($urandom_range(0, 3) == 0) pbit = ~pbit;
        last = (f == nfr - 1);
        s1   = last ? ($urandom_range(0, 5) != 0) : 1'b1;
        s2   = last ? ($urandom_range(0, 5) != 0) : 1'b1;
        send_frame(d, pbit, s1, s2, -1);
      end
      settle_compare("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
